alu_byte_seq: RTL and testbench
===============================

ALU_BYTE_SEQ -- requirements
Module: alu_byte_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; it SHALL be fixed at 32 and processed as four 8-bit slices.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start_valid, input, 1, requester presents an operation.
REQ-005 The block SHALL have port start_ready, output, 1, the block accepts an operation this cycle.
REQ-006 The block SHALL have port op, input, 3, operation code: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110/111 reserved.
REQ-007 The block SHALL have ports x and y, input, WIDTH, the operands.
REQ-008 The block SHALL have port res_valid, output, 1, result and flags are valid.
REQ-009 The block SHALL have port res_ready, input, 1, consumer takes the result.
REQ-010 The block SHALL have port result, output, WIDTH, the operation result.
REQ-011 The block SHALL have ports carry_out, overflow and zero, each output, 1: unsigned carry, signed overflow, result equals zero.
REQ-012 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-013 The block SHALL implement FSM states IDLE, EXEC and DONE, with a 2-bit slice index used in EXEC.
REQ-014 start_ready SHALL be 1 only in IDLE; accept = start_valid && start_ready.
REQ-015 On accept, the block SHALL register op, x and y, clear the result register, set the carry register (1 for SUB, else 0), set the index to 0 and go to EXEC; later input changes SHALL have no effect.
REQ-016 In each EXEC cycle, the block SHALL compute one byte, selected by the index and starting LSB first, from the registered operands, write that byte into result, and increment the index.
REQ-017 For logic ops, each byte SHALL be the bitwise function of the two operand bytes; NOR = ~(x|y).
REQ-018 For ADD, each byte SHALL be x_byte + y_byte + carry_reg; the 9th bit of the sum SHALL become carry_reg for the next slice.
REQ-019 For SUB, each byte SHALL be x_byte + ~y_byte + carry_reg, with carry_reg seeded to 1, so that carry_out=1 means no borrow.
REQ-020 For reserved ops, every byte SHALL be 0x00 and the operation SHALL still complete with normal timing.
REQ-021 After the slice with index 3, the block SHALL go to DONE; res_valid SHALL rise exactly 4 clock edges after the accepting edge.
REQ-022 In DONE, carry_out SHALL be the final carry for ADD/SUB and 0 otherwise.
REQ-023 In DONE, overflow SHALL be set for ADD/SUB when both sign bits entering the top-slice adder are equal and differ from the result sign; it SHALL be 0 otherwise.
REQ-024 In DONE, zero SHALL equal (result == 0).
REQ-025 res_valid SHALL be 1 only in DONE; result and flags SHALL hold stable while res_valid && !res_ready.
REQ-026 On res_valid && res_ready, the block SHALL go to IDLE; start_ready SHALL be 1 on the following cycle, giving a minimum of 6 cycles per operation.
REQ-027 start_valid SHALL be ignored outside IDLE, with no queuing.
REQ-028 result SHALL keep its last value in IDLE until the next accept.

Reset
REQ-029 While rst=1 at a clock edge, the state SHALL go to IDLE and the index, carry register, result, carry_out, overflow, zero, res_valid and busy SHALL all go to 0; start_ready SHALL be 1 from the following cycle.
REQ-030 Reset SHALL take priority over accept and over the result handshake, and SHALL abort an operation in EXEC or DONE with no result delivered.

Verification
REQ-031 OR, x=0xF0F00000, y=0x0F0F00FF -> result 0xFFFF00FF, res_valid exactly 4 edges after accept, carry_out=0, overflow=0, zero=0.
REQ-032 ADD 0xFFFFFFFF+0x00000001 -> result 0, carry_out=1, zero=1, overflow=0; ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1, carry_out=0.
REQ-033 SUB 5-7 -> result 0xFFFFFFFE, carry_out=0, overflow=0; SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1, carry_out=1.
REQ-034 Backpressure: hold res_ready=0 for 3 cycles in DONE with start_valid=1 -> result/flags stable, start_ready=0, no new accept; then res_ready=1 -> IDLE, next op accepted one cycle later.
REQ-035 Assert rst for one cycle while index=2 of an ADD -> next cycle all outputs 0 and start_ready=1; a following XOR 0xAAAAAAAA^0xFFFFFFFF -> 0x55555555.
REQ-036 After accepting AND 0xFFFF0000&0x00FFFF00, change x and y every cycle -> result is still 0x00FF0000.

Source files
------------

// File: rtl/alu_byte_seq.sv
// Byte-serial 32-bit ALU: an accepted operation is processed LSB slice first, one byte per cycle,
// then the result and flags are held under a valid/ready handshake until taken.
module alu_byte_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpXor = 3'b010;
  localparam logic [2:0] OpNor = 3'b011;
  localparam logic [2:0] OpAdd = 3'b100;
  localparam logic [2:0] OpSub = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  state_e           state_q;
  logic [1:0]       idx_q;
  logic             carry_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             overflow_q;
  logic             zero_q;
  logic             res_valid_q;
  logic             busy_q;
  logic             start_ready_q;

  logic [4:0]       bit_base;
  logic [7:0]       a_byte;
  logic [7:0]       b_byte;
  logic [7:0]       b_eff;
  logic [8:0]       sum9;
  logic [7:0]       slice_byte;
  logic             is_arith;
  logic             slice_ovf;
  logic [WIDTH-1:0] result_d;

  // Datapath for the slice selected by idx_q; only meaningful while in StExec.
  always_comb begin
    bit_base   = {idx_q, 3'b000};
    a_byte     = x_q[bit_base +: 8];
    b_byte     = y_q[bit_base +: 8];
    is_arith   = (op_q == OpAdd) || (op_q == OpSub);
    b_eff      = (op_q == OpSub) ? ~b_byte : b_byte;
    sum9       = {1'b0, a_byte} + {1'b0, b_eff} + {8'b0, carry_q};
    // Signed overflow is judged on the adder inputs, so SUB uses the inverted y byte.
    slice_ovf  = (a_byte[7] == b_eff[7]) && (sum9[7] != a_byte[7]);
    slice_byte = 8'h00;
    case (op_q)
      OpAnd:   slice_byte = a_byte & b_byte;
      OpOr:    slice_byte = a_byte | b_byte;
      OpXor:   slice_byte = a_byte ^ b_byte;
      OpNor:   slice_byte = ~(a_byte | b_byte);
      OpAdd,
      OpSub:   slice_byte = sum9[7:0];
      default: slice_byte = 8'h00;
    endcase
    result_d = result_q;
    result_d[bit_base +: 8] = slice_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= 2'd0;
      carry_q       <= 1'b0;
      op_q          <= 3'b000;
      x_q           <= '0;
      y_q           <= '0;
      result_q      <= '0;
      carry_out_q   <= 1'b0;
      overflow_q    <= 1'b0;
      zero_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      start_ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid) begin
            op_q          <= op;
            x_q           <= x;
            y_q           <= y;
            result_q      <= '0;
            carry_q       <= (op == OpSub);
            idx_q         <= 2'd0;
            carry_out_q   <= 1'b0;
            overflow_q    <= 1'b0;
            zero_q        <= 1'b0;
            busy_q        <= 1'b1;
            start_ready_q <= 1'b0;
            state_q       <= StExec;
          end
        end
        StExec: begin
          result_q <= result_d;
          carry_q  <= is_arith & sum9[8];
          idx_q    <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            carry_out_q <= is_arith & sum9[8];
            overflow_q  <= is_arith & slice_ovf;
            zero_q      <= (result_d == '0);
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (res_ready) begin
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: begin
          res_valid_q   <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
          state_q       <= StIdle;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign result      = result_q;
  assign carry_out   = carry_out_q;
  assign overflow    = overflow_q;
  assign zero        = zero_q;

endmodule

// File: tb/tb_alu_byte_seq.sv
// Randomized and directed bench for alu_byte_seq against a whole-word arithmetic reference model.
module tb_alu_byte_seq;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [2:0]  op;
  logic [31:0] x;
  logic [31:0] y;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_byte_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op          (op),
    .x           (x),
    .y           (y),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .zero        (zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Whole-word reference: unsigned carry means no borrow for SUB.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic c, output logic v, output logic z);
    logic [32:0] s;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a | b);
      3'd4: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd5: begin
        r = a - b;
        c = (a >= b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: r = 32'h0;
    endcase
    z = (r == 32'h0);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    logic [31:0] er;
    logic        ec, ev, ez;
    int          cnt;
    model(o, a, b, er, ec, ev, ez);
    cnt = 0;
    while (!start_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    check("start_ready_before_accept", {31'b0, start_ready}, 32'd1);
    start_valid = 1'b1;
    op = o;
    x = a;
    y = b;
    tick();
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    check("start_ready_in_exec", {31'b0, start_ready}, 32'd0);
    // Scramble inputs during EXEC; they must not affect the result or trigger a new accept.
    cnt = 0;
    while (!res_valid && cnt < 10) begin
      start_valid = 1'($urandom);
      op = 3'($urandom);
      x = $urandom;
      y = $urandom;
      tick();
      cnt++;
    end
    start_valid = 1'b0;
    check("latency", cnt, 32'd4);
    check("result", result, er);
    check("carry_out", {31'b0, carry_out}, {31'b0, ec});
    check("overflow", {31'b0, overflow}, {31'b0, ev});
    check("zero", {31'b0, zero}, {31'b0, ez});
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1;
      res_ready = 1'b0;
      tick();
      check("hold_valid", {31'b0, res_valid}, 32'd1);
      check("hold_start_ready", {31'b0, start_ready}, 32'd0);
      check("hold_result", result, er);
      check("hold_flags", {29'b0, carry_out, overflow, zero}, {29'b0, ec, ev, ez});
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("valid_after_take", {31'b0, res_valid}, 32'd0);
    check("start_ready_after_take", {31'b0, start_ready}, 32'd1);
    check("result_kept_idle", result, er);
  endtask

  logic [2:0]  dir_op [10] = '{3'd1, 3'd4, 3'd4, 3'd5, 3'd5, 3'd0, 3'd3, 3'd6, 3'd7, 3'd2};
  logic [31:0] dir_x  [10] = '{32'hF0F00000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h5, 32'h80000000,
                               32'hFFFF0000, 32'h0, 32'h12345678, 32'hFFFFFFFF, 32'hAAAAAAAA};
  logic [31:0] dir_y  [10] = '{32'h0F0F00FF, 32'h1, 32'h1, 32'h7, 32'h1,
                               32'h00FFFF00, 32'h0, 32'h9ABCDEF0, 32'h1, 32'hFFFFFFFF};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    res_ready = 1'b0;
    op = 3'd0;
    x = 32'h0;
    y = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_result", result, 32'h0);
    check("reset_flags", {28'b0, res_valid, carry_out, overflow, zero}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_start_ready", {31'b0, start_ready}, 32'd1);

    // Directed cases; the first one is held under backpressure for 3 cycles.
    for (int i = 0; i < 10; i++) do_op(dir_op[i], dir_x[i], dir_y[i], (i == 0) ? 3 : 0);

    // Reset while slice index 2 of an ADD is pending.
    start_valid = 1'b1;
    op = 3'd4;
    x = 32'h01020304;
    y = 32'h10203040;
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_result", result, 32'h0);
    check("abort_flags", {28'b0, res_valid, carry_out, overflow, zero}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_start_ready", {31'b0, start_ready}, 32'd1);
    do_op(3'd2, 32'hAAAAAAAA, 32'hFFFFFFFF, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'hFFFFFFFF;
        1: b = a;
        2: b = ~a;
        default: ;
      endcase
      do_op(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
